variable_delay_gen: RTL and testbench

- Programmable-latency response generator: each trigger pulse on trig_i produces a response on resp_o exactly cfg_delay_i cycles later.
- The delay is latched per trigger, so up to DEPTH triggers with different delays can be in flight.
- It is the stimulus/DUT side of the "a |-> ##cfg_delay b" variable-delay property. It sits between a request source and any consumer checked with that property.

---
 rtl/variable_delay_pkg.sv | 18 +
 rtl/delay_slot.sv | 62 ++++++
 rtl/variable_delay_gen.sv | 83 ++++++++
 tb/tb_variable_delay_gen.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/variable_delay_pkg.sv
// Shared types and constants for the programmable-latency response generator.
package variable_delay_pkg;

    localparam int DLY_W_DEF = 8;
    localparam int DEPTH_DEF = 4;

    typedef enum logic {S_IDLE = 1'b0, S_COUNT = 1'b1} slot_state_e;

    typedef struct packed {
        logic                 valid;
        logic [DLY_W_DEF-1:0] cnt;
    } slot_t;

    function automatic int pend_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/delay_slot.sv
// One countdown slot: loads a delay, counts down, flags expiry when cnt==1.
module delay_slot
    import variable_delay_pkg::*;
#(
    parameter int DLY_W = DLY_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             flush_i,
    input  logic [DLY_W-1:0] d_i,
    output logic             valid_o,
    output logic             expire_o
);

    slot_state_e      state_q, state_d;
    logic [DLY_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A load wins over flush and expiry so an expiring or flushed slot can be reused.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (load_i) begin
                    state_d = S_COUNT;
                    cnt_d   = d_i;
                end
            end
            S_COUNT: begin
                if (load_i) begin
                    cnt_d = d_i;
                end else if (flush_i || cnt_q == DLY_W'(1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - DLY_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        valid_o  = (state_q == S_COUNT);
        expire_o = (state_q == S_COUNT) && (cnt_q == DLY_W'(1));
    end

endmodule

// File: rtl/variable_delay_gen.sv
// Programmable-latency response generator: each trigger yields a resp_o pulse cfg_delay_i cycles later.
module variable_delay_gen
    import variable_delay_pkg::*;
#(
    parameter int DLY_W = DLY_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       trig_i,
    input  logic [DLY_W-1:0]           cfg_delay_i,
    input  logic                       clear_i,
    output logic                       resp_o,
    output logic                       busy_o,
    output logic [$clog2(DEPTH+1)-1:0] pending_o,
    output logic                       overflow_o,
    output logic                       coalesce_o
);

    localparam int PEND_W = pend_w(DEPTH);

    logic [DEPTH-1:0]  valid, expire, free, load;
    logic              accept, drop, found;
    logic [PEND_W-1:0] n_valid, n_expire;

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        delay_slot #(.DLY_W(DLY_W)) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .load_i   (load[i]),
            .flush_i  (clear_i),
            .d_i      (cfg_delay_i),
            .valid_o  (valid[i]),
            .expire_o (expire[i])
        );
    end

    assign accept = trig_i && (cfg_delay_i != '0);
    // A slot expiring this edge is free, and a flush frees everything.
    assign free   = ~valid | expire | {DEPTH{clear_i}};
    assign drop   = accept && !(|free);

    always_comb begin
        load  = '0;
        found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (free[i] && !found) begin
                load[i] = accept;
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        n_valid  = '0;
        n_expire = '0;
        for (int i = 0; i < DEPTH; i++) begin
            n_valid  = n_valid  + PEND_W'(valid[i]);
            n_expire = n_expire + PEND_W'(expire[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_o <= 1'b0;
            coalesce_o <= 1'b0;
        end else if (clear_i) begin
            overflow_o <= 1'b0;
            coalesce_o <= 1'b0;
        end else begin
            if (drop)
                overflow_o <= 1'b1;
            if (n_expire >= PEND_W'(2))
                coalesce_o <= 1'b1;
        end
    end

    // d=0 bypass is the only input-to-output path; gated so reset silences it too.
    assign resp_o    = rst_n && ((|expire) || (trig_i && cfg_delay_i == '0));
    assign busy_o    = |valid;
    assign pending_o = n_valid;

endmodule

// File: tb/tb_variable_delay_gen.sv
// Directed self-checking bench for variable_delay_gen (DLY_W=8, DEPTH=4).
module tb_variable_delay_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       trig_i;
    logic [7:0] cfg_delay_i;
    logic       clear_i;
    logic       resp_o, busy_o, overflow_o, coalesce_o;
    logic [2:0] pending_o;
    logic       resp_s;
    int         checks = 0;
    int         errors = 0;

    variable_delay_gen #(.DLY_W(8), .DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .trig_i      (trig_i),
        .cfg_delay_i (cfg_delay_i),
        .clear_i     (clear_i),
        .resp_o      (resp_o),
        .busy_o      (busy_o),
        .pending_o   (pending_o),
        .overflow_o  (overflow_o),
        .coalesce_o  (coalesce_o)
    );

    always #5 clk = ~clk;

    // One cycle: drive at negedge, capture resp_o as sampled by the coming edge, then settle after it.
    task automatic step(input logic t, input logic [7:0] d, input logic c);
        @(negedge clk);
        trig_i = t; cfg_delay_i = d; clear_i = c;
        #1 resp_s = resp_o;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; trig_i = 1'b0; cfg_delay_i = '0; clear_i = 1'b0;
        #12;
        checks++;
        if ({resp_o, busy_o, pending_o, overflow_o, coalesce_o} !== 7'b0) begin
            errors++;
            $display("FAIL reset_state: got %b want 0000000",
                     {resp_o, busy_o, pending_o, overflow_o, coalesce_o});
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_basic();
        for (int k = 1; k <= 6; k++) begin
            step(k == 1, 8'd4, 1'b0);
            checks++;
            if (resp_s !== (k == 5)) begin
                errors++; $display("FAIL basic_resp edge %0d: got %b want %b", k, resp_s, k == 5);
            end
            checks++;
            if (busy_o !== (k <= 4) || pending_o !== ((k <= 4) ? 3'd1 : 3'd0)) begin
                errors++; $display("FAIL basic_busy edge %0d: got busy=%b pend=%0d", k, busy_o, pending_o);
            end
        end
    endtask

    task automatic test_out_of_order();
        for (int k = 1; k <= 8; k++) begin
            step(k <= 2, (k == 1) ? 8'd6 : 8'd2, 1'b0);
            checks++;
            if (resp_s !== (k == 4 || k == 7)) begin
                errors++; $display("FAIL ooo_resp edge %0d: got %b want %b", k, resp_s, k == 4 || k == 7);
            end
        end
        checks++;
        if (coalesce_o !== 1'b0) begin
            errors++; $display("FAIL ooo_coalesce: got %b want 0", coalesce_o);
        end
    endtask

    task automatic test_coalesce();
        int pulses = 0;
        for (int k = 1; k <= 6; k++) begin
            step(k <= 2, (k == 1) ? 8'd3 : 8'd2, 1'b0);
            pulses += int'(resp_s);
            checks++;
            if (resp_s !== (k == 4)) begin
                errors++; $display("FAIL coal_resp edge %0d: got %b want %b", k, resp_s, k == 4);
            end
            checks++;
            if (coalesce_o !== (k >= 4)) begin
                errors++; $display("FAIL coal_flag edge %0d: got %b want %b", k, coalesce_o, k >= 4);
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++; $display("FAIL coal_pulses: got %0d want 1", pulses);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 1; k <= 12; k++) begin
            step(k <= 10, 8'd1, 1'b0);
            checks++;
            if (resp_s !== (k >= 2 && k <= 11)) begin
                errors++; $display("FAIL b2b_resp edge %0d: got %b want %b", k, resp_s, k >= 2 && k <= 11);
            end
        end
        checks++;
        if (overflow_o !== 1'b0 || pending_o !== 3'd0) begin
            errors++; $display("FAIL b2b_state: got ovf=%b pend=%0d want 0/0", overflow_o, pending_o);
        end
    endtask

    task automatic test_overflow();
        int pulses = 0;
        step(1'b0, 8'd0, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            step(k <= 5, 8'd10, 1'b0);
            pulses += int'(resp_s);
            checks++;
            if (resp_s !== (k >= 11 && k <= 14)) begin
                errors++; $display("FAIL ovf_resp edge %0d: got %b want %b", k, resp_s, k >= 11 && k <= 14);
            end
            checks++;
            if (overflow_o !== (k >= 5)) begin
                errors++; $display("FAIL ovf_flag edge %0d: got %b want %b", k, overflow_o, k >= 5);
            end
        end
        checks++;
        if (pulses != 4) begin
            errors++; $display("FAIL ovf_pulses: got %0d want 4", pulses);
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        trig_i = 1'b1; cfg_delay_i = 8'd0; clear_i = 1'b0;
        #1;
        checks++;
        if (resp_o !== 1'b1) begin
            errors++; $display("FAIL bypass_resp: got %b want 1", resp_o);
        end
        @(posedge clk); #1;
        checks++;
        if (pending_o !== 3'd0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL bypass_pending: got pend=%0d busy=%b want 0/0", pending_o, busy_o);
        end
        step(1'b0, 8'd0, 1'b0);
        checks++;
        if (resp_s !== 1'b0) begin
            errors++; $display("FAIL bypass_idle: got %b want 0", resp_s);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 8'd5, 1'b0);
        step(1'b0, 8'd5, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (resp_o !== 1'b0 || busy_o !== 1'b0 || pending_o !== 3'd0 || coalesce_o !== 1'b0) begin
            errors++; $display("FAIL rst_mid: got resp=%b busy=%b pend=%0d coal=%b", resp_o, busy_o, pending_o, coalesce_o);
        end
        trig_i = 1'b1; cfg_delay_i = 8'd0;
        #1;
        checks++;
        if (resp_o !== 1'b0) begin
            errors++; $display("FAIL rst_bypass: got %b want 0", resp_o);
        end
        trig_i = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, 8'd0, 1'b0);
            checks++;
            if (resp_s !== 1'b0) begin
                errors++; $display("FAIL rst_after edge %0d: got %b want 0", k, resp_s);
            end
        end
    endtask

    task automatic test_clear();
        for (int k = 1; k <= 7; k++)
            step(1'b1, (k == 1) ? 8'd3 : (k == 2) ? 8'd2 : 8'd30, 1'b0);
        checks++;
        if (overflow_o !== 1'b1 || coalesce_o !== 1'b1 || pending_o !== 3'd4) begin
            errors++; $display("FAIL clr_setup: got ovf=%b coal=%b pend=%0d want 1/1/4", overflow_o, coalesce_o, pending_o);
        end
        for (int k = 1; k <= 8; k++) begin
            step(k == 3, (k == 3) ? 8'd2 : 8'd30, k == 3);
            checks++;
            if (resp_s !== (k == 5)) begin
                errors++; $display("FAIL clr_resp edge %0d: got %b want %b", k, resp_s, k == 5);
            end
            if (k == 3) begin
                checks++;
                if (overflow_o !== 1'b0 || coalesce_o !== 1'b0 || pending_o !== 3'd1) begin
                    errors++; $display("FAIL clr_flags: got ovf=%b coal=%b pend=%0d want 0/0/1", overflow_o, coalesce_o, pending_o);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_out_of_order();
        test_coalesce();
        test_back_to_back();
        test_overflow();
        test_bypass();
        test_reset_mid();
        test_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
